if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC, drives the

---
 rtl/if_fetch_stage.sv | 126 ++++++++++++
 tb/tb_if_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_stage
//  Purpose  : RV32I instruction-fetch stage. Owns the PC, addresses the
//             async-read instruction ROM and registers the IF/ID pair.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          IMEM_AW   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc_o,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    output logic               id_valid,
    output logic               misalign_err,
    output logic [31:0]        fetch_cnt,
    output logic [1:0]         state_o
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic        r_id_valid;
    logic        r_misalign_err;
    logic [31:0] r_fetch_cnt;
    logic        w_do_redirect;
    logic        w_do_fetch;
    logic        w_in_range;

    // Addresses above the ROM window fetch a bubble instead of aliasing.
    assign w_in_range = (r_pc[31:IMEM_AW+2] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else if (en) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_BOOT:  w_state_next = S_RUN;
                S_RUN:   w_state_next = stall ? S_HOLD : S_RUN;
                S_HOLD:  w_state_next = stall ? S_HOLD : S_RUN;
                default: w_state_next = S_RUN;
            endcase
        end
    end

    always_comb begin
        w_do_redirect = 1'b0;
        w_do_fetch    = 1'b0;
        if (redirect) begin
            w_do_redirect = 1'b1;
        end else begin
            case (r_state)
                S_RUN, S_HOLD: w_do_fetch = ~stall;
                default:       w_do_fetch = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_id_instr     <= NOP_INSTR;
            r_id_pc        <= 32'd0;
            r_id_valid     <= 1'b0;
            r_misalign_err <= 1'b0;
            r_fetch_cnt    <= 32'd0;
        end else if (en) begin
            if (w_do_redirect) begin
                r_pc       <= {redirect_pc[31:2], 2'b00};
                r_id_instr <= NOP_INSTR;
                r_id_pc    <= 32'd0;
                r_id_valid <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) begin
                    r_misalign_err <= 1'b1;
                end
            end else if (w_do_fetch) begin
                r_pc    <= r_pc + 32'd4;
                r_id_pc <= r_pc;
                if (w_in_range) begin
                    r_id_instr  <= imem_rdata;
                    r_id_valid  <= 1'b1;
                    r_fetch_cnt <= r_fetch_cnt + 32'd1;
                end else begin
                    r_id_instr <= NOP_INSTR;
                    r_id_valid <= 1'b0;
                end
            end
        end
    end

    assign imem_addr    = r_pc[IMEM_AW+1:2];
    assign pc_o         = r_pc;
    assign id_instr     = r_id_instr;
    assign id_pc        = r_id_pc;
    assign id_valid     = r_id_valid;
    assign misalign_err = r_misalign_err;
    assign fetch_cnt    = r_fetch_cnt;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Purpose  : Directed plus randomized bench for if_fetch_stage against a
//             step-level behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_o;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        misalign_err;
    logic [31:0] fetch_cnt;
    logic [1:0]  state_o;

    logic [31:0] rom [64];

    int checks = 0;
    int errors = 0;

    // Model state: booted/held flags rather than a state code.
    logic [31:0] m_pc, m_instr, m_idpc, m_cnt;
    logic        m_valid, m_err, m_booted, m_held;

    always #5 clk = ~clk;

    assign imem_rdata = rom[imem_addr];

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013),
        .IMEM_AW  (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc_o        (pc_o),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .misalign_err(misalign_err),
        .fetch_cnt   (fetch_cnt),
        .state_o     (state_o)
    );

    task automatic check_one(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_state;
        exp_state = !m_booted ? 32'd0 : (m_held ? 32'd2 : 32'd1);
        check_one({tag, "_pc"},    pc_o, m_pc);
        check_one({tag, "_addr"},  {26'd0, imem_addr}, {26'd0, m_pc[7:2]});
        check_one({tag, "_instr"}, id_instr, m_instr);
        check_one({tag, "_idpc"},  id_pc, m_idpc);
        check_one({tag, "_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
        check_one({tag, "_err"},   {31'd0, misalign_err}, {31'd0, m_err});
        check_one({tag, "_cnt"},   fetch_cnt, m_cnt);
        check_one({tag, "_state"}, {30'd0, state_o}, exp_state);
    endtask

    task automatic model_step(input logic r, input logic e, input logic s,
                              input logic d, input logic [31:0] t);
        if (r) begin
            m_pc = 32'd0; m_instr = c_nop; m_idpc = 32'd0; m_valid = 1'b0;
            m_err = 1'b0; m_cnt = 32'd0; m_booted = 1'b0; m_held = 1'b0;
        end else if (e) begin
            if (d) begin
                m_pc = t & 32'hFFFF_FFFC;
                m_instr = c_nop; m_idpc = 32'd0; m_valid = 1'b0;
                if (t % 4 != 0) m_err = 1'b1;
                m_booted = 1'b1; m_held = 1'b0;
            end else if (!m_booted) begin
                m_booted = 1'b1;
            end else if (s) begin
                m_held = 1'b1;
            end else begin
                m_held = 1'b0;
                m_idpc = m_pc;
                if (m_pc < 32'd256) begin
                    m_instr = rom[m_pc / 4];
                    m_valid = 1'b1;
                    m_cnt = m_cnt + 1;
                end else begin
                    m_instr = c_nop;
                    m_valid = 1'b0;
                end
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic s,
                        input logic d, input logic [31:0] t);
        rst = r; en = e; stall = s; redirect = d; redirect_pc = t;
        @(posedge clk);
        model_step(r, e, s, d, t);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] cnt_snap;
        logic        r, e, s, d;
        logic [31:0] t;

        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h0010_0093;
        rom[1] = 32'h0020_0113;

        // Boot and first two fetches
        step("rst", 1, 1, 0, 0, 0);
        check_one("rst_instr", id_instr, c_nop);
        step("boot", 0, 1, 0, 0, 0);
        step("f0", 0, 1, 0, 0, 0);
        check_one("t1_instr0", id_instr, 32'h0010_0093);
        step("f1", 0, 1, 0, 0, 0);
        check_one("t1_instr1", id_instr, 32'h0020_0113);
        check_one("t1_cnt", fetch_cnt, 32'd2);

        // Stall at pc=8
        for (int i = 0; i < 3; i++) step("stall", 0, 1, 1, 0, 0);
        check_one("t2_pc", pc_o, 32'd8);
        check_one("t2_state", {30'd0, state_o}, 32'd2);
        step("release", 0, 1, 0, 0, 0);
        check_one("t2_idpc", id_pc, 32'd8);

        // Redirect overrides stall
        step("redir", 0, 1, 1, 1, 32'h20);
        check_one("t3_pc", pc_o, 32'h20);
        step("after_redir", 0, 1, 0, 0, 0);
        check_one("t3_idpc", id_pc, 32'h20);

        // Misaligned target
        step("misal", 0, 1, 0, 1, 32'h22);
        check_one("t4_err", {31'd0, misalign_err}, 32'd1);
        step("misal_run", 0, 1, 0, 0, 0);

        // Walk off the end of the ROM
        step("to_top", 0, 1, 0, 1, 32'hF8);
        cnt_snap = m_cnt;
        step("top0", 0, 1, 0, 0, 0);
        step("top1", 0, 1, 0, 0, 0);
        step("oor", 0, 1, 0, 0, 0);
        check_one("t5_pc", pc_o, 32'h104);
        check_one("t5_cnt", fetch_cnt, cnt_snap + 32'd2);

        // PC wrap from the top of the address space
        step("to_wrap", 0, 1, 0, 1, 32'hFFFF_FFFC);
        step("wrap", 0, 1, 0, 0, 0);
        check_one("wrap_pc", pc_o, 32'd0);
        step("wrap_f", 0, 1, 0, 0, 0);

        // en=0 freezes everything, rst still works
        for (int i = 0; i < 6; i++)
            step("en0", 0, 0, 1'(i % 2), 1'(i / 2 % 2), 32'h43);
        step("rst_en0", 1, 0, 0, 0, 0);
        check_one("t6_cnt", fetch_cnt, 32'd0);
        check_one("t6_state", {30'd0, state_o}, 32'd0);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 9) == 0);
            t = 32'($urandom_range(0, 300));
            if ($urandom_range(0, 7) == 0) t = $urandom;
            step("rnd", r, e, s, d, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
